// File: rtl/present_decrypt_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : present_decrypt_iter_pkg
// Description : Shared constants for the PRESENT-80 cores: round count,
//               FSM encodings and the forward / inverse S-box tables.
// Revision    : 1.0 - initial release
// ============================================================================
package present_decrypt_iter_pkg;

  localparam int ROUNDS = 31;
  localparam int CNT_W  = 5;
  localparam logic [CNT_W-1:0] LAST_ROUND = 5'(ROUNDS);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_EXPAND  = 3'd1;
  localparam logic [2:0] ST_WHITEN  = 3'd2;
  localparam logic [2:0] ST_DECRYPT = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Nibble x of each table holds S(x) / S^-1(x); entry 0 sits in the LSBs.
  localparam logic [63:0] SBOX_FWD = 64'h2174_8FE3_DA09_B65C;
  localparam logic [63:0] SBOX_INV = 64'hA970_364B_D21C_8FE5;

  function automatic logic [3:0] sbox_lookup(input logic [63:0] tbl, input logic [3:0] x);
    return tbl[{x, 2'b00} +: 4];
  endfunction

endpackage
`default_nettype wire

// File: rtl/present_decrypt_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : present_decrypt_iter_if
// Description : Job-in / result-out valid-ready bus of the decryption core.
// Revision    : 1.0 - initial release
// ============================================================================
interface present_decrypt_iter_if;

  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_c;
  logic [79:0] in_k;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_p;

  // Producer / consumer side of the core
  modport master (
    output in_valid, in_c, in_k, out_ready,
    input  in_ready, out_valid, out_p
  );

  // The decryption core itself
  modport slave (
    input  in_valid, in_c, in_k, out_ready,
    output in_ready, out_valid, out_p
  );

endinterface
`default_nettype wire

// File: rtl/present_decrypt_iter_sbox.sv
`default_nettype none
// ============================================================================
// Module      : sbox
// Description : PRESENT forward 4-bit S-box, combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module sbox
  import present_decrypt_iter_pkg::*;
(
  input  logic [3:0] i_x,
  output logic [3:0] o_y
);

  assign o_y = sbox_lookup(SBOX_FWD, i_x);

endmodule
`default_nettype wire

// File: rtl/present_decrypt_iter_sbox_inv.sv
`default_nettype none
// ============================================================================
// Module      : sbox_inv
// Description : PRESENT inverse 4-bit S-box, combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_inv
  import present_decrypt_iter_pkg::*;
(
  input  logic [3:0] i_x,
  output logic [3:0] o_y
);

  assign o_y = sbox_lookup(SBOX_INV, i_x);

endmodule
`default_nettype wire

// File: rtl/present_decrypt_iter.sv
`default_nettype none
// ============================================================================
// Module      : present_decrypt_iter
// Description : Iterative PRESENT-80 decryption. Rolls the user key forward
//               to K32, whitens, then runs 31 inverse rounds one per cycle
//               while stepping the key schedule backwards.
// Revision    : 1.0 - initial release
// ============================================================================
module present_decrypt_iter
  import present_decrypt_iter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  present_decrypt_iter_if.slave bus
);

  logic [2:0]       r_fsm;
  logic [2:0]       w_fsm_nxt;
  logic [63:0]      r_state;
  logic [79:0]      r_key;
  logic [CNT_W-1:0] r_cnt;

  // ---------------- forward key update (EXPAND) ----------------
  logic [79:0] w_key_rot;
  logic [3:0]  w_key_fwd_nib;
  logic [79:0] w_key_fwd;

  assign w_key_rot = {r_key[18:0], r_key[79:19]};

  sbox u_sbox_key (
    .i_x (w_key_rot[79:76]),
    .o_y (w_key_fwd_nib)
  );

  assign w_key_fwd = {w_key_fwd_nib, w_key_rot[75:20], w_key_rot[19:15] ^ r_cnt, w_key_rot[14:0]};

  // ---------------- inverse key update (DECRYPT) ----------------
  // Undo the forward steps in reverse order: counter XOR, S-box, rotation.
  logic [79:0] w_key_xor;
  logic [3:0]  w_key_inv_nib;
  logic [79:0] w_key_sub;
  logic [79:0] w_key_inv;

  assign w_key_xor = {r_key[79:20], r_key[19:15] ^ r_cnt, r_key[14:0]};

  sbox_inv u_sbox_inv_key (
    .i_x (w_key_xor[79:76]),
    .o_y (w_key_inv_nib)
  );

  assign w_key_sub = {w_key_inv_nib, w_key_xor[75:0]};
  assign w_key_inv = {w_key_sub[60:0], w_key_sub[79:61]};

  // ---------------- inverse round datapath ----------------
  logic [63:0] w_perm;
  logic [63:0] w_sub;
  logic [63:0] w_dec;

  for (genvar j = 0; j < 64; j++) begin : g_invp
    assign w_perm[4*(j%16) + j/16] = r_state[j];
  end

  for (genvar n = 0; n < 16; n++) begin : g_sinv
    sbox_inv u_sbox_inv (
      .i_x (w_perm[4*n +: 4]),
      .o_y (w_sub[4*n +: 4])
    );
  end

  assign w_dec = w_sub ^ w_key_inv[79:16];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= ST_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  // FSM next-state decode
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      ST_IDLE:    if (bus.in_valid)             w_fsm_nxt = ST_EXPAND;
      ST_EXPAND:  if (r_cnt == LAST_ROUND)      w_fsm_nxt = ST_WHITEN;
      ST_WHITEN:                                w_fsm_nxt = ST_DECRYPT;
      ST_DECRYPT: if (r_cnt == 5'd1)            w_fsm_nxt = ST_DONE;
      ST_DONE:    if (bus.out_ready)            w_fsm_nxt = ST_IDLE;
      default:                                  w_fsm_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs; in_ready is also held low while reset is asserted
  always_comb begin
    bus.in_ready  = (r_fsm == ST_IDLE) && rst_n;
    bus.out_valid = (r_fsm == ST_DONE);
  end

  assign bus.out_p = r_state;

  // Datapath registers: load, key expansion, whitening, inverse rounds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_key   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_state <= bus.in_c;
            r_key   <= bus.in_k;
            r_cnt   <= 5'd1;
          end
        end
        ST_EXPAND: begin
          r_key <= w_key_fwd;
          r_cnt <= r_cnt + 5'd1;
        end
        ST_WHITEN: begin
          r_state <= r_state ^ r_key[79:16];
          r_cnt   <= LAST_ROUND;
        end
        ST_DECRYPT: begin
          r_state <= w_dec;
          r_key   <= w_key_inv;
          r_cnt   <= r_cnt - 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_present_decrypt_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_present_decrypt_iter
// Description : Self-checking bench for the PRESENT-80 decryption core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_present_decrypt_iter;

  localparam int N_RANDOM = 600;
  localparam int BOUND    = 200;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  present_decrypt_iter_if bus();

  present_decrypt_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference S-box, written as a case table
  function automatic logic [3:0] ref_s(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
      4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
      4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
      4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
    endcase
  endfunction

  // Reference PRESENT-80 encryption
  function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [79:0] key);
    logic [63:0] s;
    logic [63:0] t;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int i = 1; i <= 31; i++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = ref_s(s[4*n +: 4]);
      for (int j = 0; j < 64; j++) t[(j == 63) ? 63 : (16*j) % 63] = s[j];
      s = t;
      k = {k[18:0], k[79:19]};
      k[79:76] = ref_s(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(i);
    end
    return s ^ k[79:16];
  endfunction

  // Drive one job, return result and cycles from accept edge to out_valid
  task automatic do_job(input logic [63:0] c, input logic [79:0] k,
                        output logic [63:0] p, output int lat, output bit to);
    int n;
    to = 1'b0;
    p = '0;
    lat = 0;
    bus.in_c = c;
    bus.in_k = k;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < BOUND) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      to = 1'b1;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < BOUND) begin
      @(posedge clk); #1; lat++;
    end
    if (!bus.out_valid) to = 1'b1;
    p = bus.out_p;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_held got=%b exp=0", bus.in_ready); end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++;
    if (bus.out_p !== 64'h0) begin n_fail++; $display("FAIL rst_out_p got=%h exp=0", bus.out_p); end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready got=%b exp=1", bus.in_ready); end
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_idle_out_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_known_vectors();
    logic [63:0] p;
    int lat;
    bit to;
    do_job(64'h5579C1387B228445, 80'h0, p, lat, to);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL kv0_timeout got=%b exp=0", to); end
    n_checks++;
    if (p !== 64'h0) begin n_fail++; $display("FAIL kv0_out_p got=%h exp=%h", p, 64'h0); end
    n_checks++;
    if (lat != 63) begin n_fail++; $display("FAIL kv0_latency got=%0d exp=63", lat); end
    do_job(64'hE72C46C0F5945049, {80{1'b1}}, p, lat, to);
    n_checks++;
    if (p !== 64'h0) begin n_fail++; $display("FAIL kv1_out_p got=%h exp=%h", p, 64'h0); end
    n_checks++;
    if (lat != 63) begin n_fail++; $display("FAIL kv1_latency got=%0d exp=63", lat); end
  endtask

  task automatic test_back_to_back();
    int  lat;
    bit  busy_ready;
    bus.in_c = 64'hA112FFC72F68417B;
    bus.in_k = 80'h0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_c = 64'h3333DCD3213210D2;
    bus.in_k = {80{1'b1}};
    lat = 0;
    busy_ready = 1'b0;
    while (!bus.out_valid && lat < BOUND) begin
      if (bus.in_ready) busy_ready = 1'b1;
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (bus.out_p !== 64'hFFFFFFFFFFFFFFFF) begin n_fail++; $display("FAIL b2b_job0_out_p got=%h exp=%h", bus.out_p, 64'hFFFFFFFFFFFFFFFF); end
    n_checks++;
    if (lat != 63) begin n_fail++; $display("FAIL b2b_job0_latency got=%0d exp=63", lat); end
    n_checks++;
    if (busy_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_while_busy got=%b exp=0", busy_ready); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_ready got=%b exp=1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_job1_accepted got=%b exp=0", bus.in_ready); end
    lat = 0;
    while (!bus.out_valid && lat < BOUND) begin
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (bus.out_p !== 64'hFFFFFFFFFFFFFFFF) begin n_fail++; $display("FAIL b2b_job1_out_p got=%h exp=%h", bus.out_p, 64'hFFFFFFFFFFFFFFFF); end
    n_checks++;
    if (lat != 63) begin n_fail++; $display("FAIL b2b_job1_latency got=%0d exp=63", lat); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    bit hold_ok;
    bus.in_c = 64'hA112FFC72F68417B;
    bus.in_k = 80'h0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < BOUND) begin
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_reach_done got=%b exp=1", bus.out_valid); end
    bus.in_c = 64'hE72C46C0F5945049;
    bus.in_k = {80{1'b1}};
    bus.in_valid = 1'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid !== 1'b1 || bus.out_p !== 64'hFFFFFFFFFFFFFFFF || bus.in_ready !== 1'b0) begin
        hold_ok = 1'b0;
        $display("FAIL bp_hold cycle=%0d out_valid=%b out_p=%h in_ready=%b exp 1/%h/0",
                 i, bus.out_valid, bus.out_p, bus.in_ready, 64'hFFFFFFFFFFFFFFFF);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (hold_ok !== 1'b1) n_fail++;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_first_idle_accept got=%b exp=0", bus.in_ready); end
    lat = 0;
    while (!bus.out_valid && lat < BOUND) begin
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (bus.out_p !== 64'h0 || lat != 63) begin
      n_fail++; $display("FAIL bp_next_job out_p=%h lat=%0d exp %h/63", bus.out_p, lat, 64'h0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_midjob();
    logic [63:0] p;
    int lat;
    bit to;
    bus.in_c = 64'h5579C1387B228445;
    bus.in_k = 80'h0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    // 48 more edges leaves the round counter at 15 inside DECRYPT
    repeat (48) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs out_valid=%b in_ready=%b exp 0/0", bus.out_valid, bus.in_ready);
    end
    n_checks++;
    if (bus.out_p !== 64'h0) begin n_fail++; $display("FAIL midrst_out_p got=%h exp=0", bus.out_p); end
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_release_ready got=%b exp=1", bus.in_ready); end
    @(posedge clk); #1;
    do_job(64'h3333DCD3213210D2, {80{1'b1}}, p, lat, to);
    n_checks++;
    if (to !== 1'b0 || p !== 64'hFFFFFFFFFFFFFFFF || lat != 63) begin
      n_fail++; $display("FAIL midrst_fresh_job out_p=%h lat=%0d to=%b exp %h/63/0", p, lat, to, 64'hFFFFFFFFFFFFFFFF);
    end
  endtask

  task automatic test_random();
    logic [79:0] key;
    logic [63:0] pt;
    logic [63:0] ct;
    int  n;
    int  lat;
    bit  accepted;
    bit  bad_ack;
    for (int j = 0; j < N_RANDOM; j++) begin
      key = {$urandom, $urandom, 16'($urandom)};
      pt  = {$urandom, $urandom};
      ct  = ref_enc(pt, key);
      bus.in_c = ct;
      bus.in_k = key;
      accepted = 1'b0;
      n = 0;
      while (!accepted && n < BOUND) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        if (bus.in_valid && bus.in_ready) accepted = 1'b1;
        @(posedge clk); #1; n++;
      end
      n_checks++;
      if (!accepted) begin
        n_fail++; $display("FAIL rnd_accept job=%0d not accepted", j);
        bus.in_valid = 1'b0;
        continue;
      end
      lat = 0;
      bad_ack = 1'b0;
      while (!bus.out_valid && lat < BOUND) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_c = {$urandom, $urandom};
        bus.in_k = {$urandom, $urandom, 16'($urandom)};
        if (bus.in_ready) bad_ack = 1'b1;
        @(posedge clk); #1; lat++;
      end
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_p !== pt) begin n_fail++; $display("FAIL rnd_out_p job=%0d key=%h got=%h exp=%h", j, key, bus.out_p, pt); end
      n_checks++;
      if (lat != 63) begin n_fail++; $display("FAIL rnd_latency job=%0d got=%0d exp=63", j, lat); end
      n_checks++;
      if (bad_ack !== 1'b0) begin n_fail++; $display("FAIL rnd_ready_while_busy job=%0d got=%b exp=0", j, bad_ack); end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_c = '0;
    bus.in_k = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_known_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_midjob();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
